// File: rtl/z_core_pkg.sv
// Shared definitions for the Z-Core load/store unit: funct3 width codes, FSM states
// and the funct3 legality / alignment rules.
package z_core_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Doubleword accesses and LWU only exist on the 64-bit core.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3, input logic is64);
        logic ok;
        if (we) begin
            ok = is64 ? (f3 <= F3_D) : (f3 <= F3_W);
        end else begin
            case (f3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
                F3_D, F3_WU:                    ok = is64;
                default:                        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [2:0] addr_lo);
        logic mis;
        case (f3[1:0])
            2'd1:    mis = addr_lo[0];
            2'd2:    mis = |addr_lo[1:0];
            2'd3:    mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/z_core_lsu_align.sv
// Combinational lane logic: byte enables and replicated store data for writes,
// lane select plus sign/zero extension for reads.
module z_core_lsu_align
    import z_core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]        funct3,
    input  logic [OFF_W-1:0]  offset,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   load_word,
    output logic [XLEN/8-1:0] byte_en,
    output logic [XLEN-1:0]   store_lanes,
    output logic [XLEN-1:0]   load_data
);
    localparam int NB = XLEN / 8;

    logic [1:0]    size;
    logic [7:0]    size_mask;
    logic [15:0]   be_wide;
    logic [XLEN-1:0] shifted;

    assign size = funct3[1:0];

    // Each lane repeats the byte of the access that lands on it, so any aligned offset sees its data.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign store_lanes[8*gi +: 8] =
                (size == 2'd0) ? store_data[7:0] :
                (size == 2'd1) ? store_data[8*(gi % 2) +: 8] :
                (size == 2'd2) ? store_data[8*(gi % 4) +: 8] :
                                 store_data[8*(gi % 8) +: 8];
        end
    endgenerate

    always_comb begin
        size_mask = 8'h01;
        case (size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign be_wide = {8'h00, size_mask} << offset;
    assign byte_en = be_wide[NB-1:0];

    assign shifted = load_word >> {offset, 3'b000};

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = XLEN'($signed(shifted[7:0]));
            F3_H:    load_data = XLEN'($signed(shifted[15:0]));
            F3_W:    load_data = XLEN'($signed(shifted[31:0]));
            F3_BU:   load_data = XLEN'(shifted[7:0]);
            F3_HU:   load_data = XLEN'(shifted[15:0]);
            F3_WU:   load_data = XLEN'(shifted[31:0]);
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/z_core_lsu.sv
// Z-Core load/store unit: accepts one request at a time, runs it over a stallable
// memory bus with timeout, and returns a single-cycle response.
module z_core_lsu
    import z_core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_misalign,
    output logic              rsp_fault,
    output logic              mem_req,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_data_out,
    output logic [XLEN/8-1:0] mem_byte_en,
    input  logic [XLEN-1:0]   mem_data_in,
    input  logic              mem_ready
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_t        state_reg, state_next;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [XLEN-1:0]   rdata_reg;
    logic              misalign_reg;
    logic              fault_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              accept, illegal, misaligned, timeout_hit, in_bus, in_resp;
    logic [NB-1:0]     byte_en;
    logic [XLEN-1:0]   store_lanes, load_data;

    assign accept      = req_valid && (state_reg == IDLE);
    assign illegal     = !f3_legal(req_we, req_funct3, XLEN == 64);
    assign misaligned  = f3_misaligned(req_funct3, req_addr[2:0]);
    assign timeout_hit = (TIMEOUT != 0) && (count_reg == TO_LAST);
    assign in_bus      = (state_reg == BUS);
    assign in_resp     = (state_reg == RESP);

    z_core_lsu_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
        .funct3      (funct3_reg),
        .offset      (addr_reg[OFF_W-1:0]),
        .store_data  (wdata_reg),
        .load_word   (mem_data_in),
        .byte_en     (byte_en),
        .store_lanes (store_lanes),
        .load_data   (load_data)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (illegal || misaligned) ? RESP : BUS;
            BUS:  if (mem_ready || timeout_hit) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            funct3_reg   <= 3'd0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            misalign_reg <= 1'b0;
            fault_reg    <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    count_reg <= '0;
                    if (accept) begin
                        we_reg       <= req_we;
                        funct3_reg   <= req_funct3;
                        addr_reg     <= req_addr;
                        wdata_reg    <= req_wdata;
                        rdata_reg    <= '0;
                        fault_reg    <= illegal;
                        misalign_reg <= !illegal && misaligned;
                    end
                end
                BUS: begin
                    if (mem_ready) begin
                        rdata_reg <= we_reg ? '0 : load_data;
                        count_reg <= '0;
                    end else if (timeout_hit) begin
                        fault_reg <= 1'b1;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                default: begin
                    rdata_reg    <= '0;
                    misalign_reg <= 1'b0;
                    fault_reg    <= 1'b0;
                end
            endcase
        end
    end

    // Bus and response outputs are gated by state so they read zero whenever idle.
    assign req_ready    = (state_reg == IDLE);
    assign mem_req      = in_bus;
    assign mem_write_en = in_bus && we_reg;
    assign mem_addr     = in_bus ? {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_data_out = in_bus ? store_lanes : '0;
    assign mem_byte_en  = in_bus ? byte_en : '0;
    assign rsp_valid    = in_resp;
    assign rsp_rdata    = in_resp ? rdata_reg : '0;
    assign rsp_misalign = in_resp && misalign_reg;
    assign rsp_fault    = in_resp && fault_reg;

endmodule

// File: tb/tb_z_core_lsu.sv
// Self-checking bench for z_core_lsu (XLEN=32, TIMEOUT=4): directed cases plus
// randomized accesses checked against a behavioural model of the access rules.
module tb_z_core_lsu;
    localparam int XLEN    = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        rsp_fault;
    logic        mem_req;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_data_in = '0;
    logic        mem_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] rsp_cyc;
        logic [31:0] rdata;
        logic [31:0] bus_cyc;
        logic [31:0] addr;
        logic [31:0] dout;
        logic [3:0]  be;
        logic        misalign;
        logic        fault;
        logic        we_seen;
        logic        stable;
        logic        pulse_ok;
        logic        timed_out;
    } obs_t;

    z_core_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_misalign (rsp_misalign),
        .rsp_fault    (rsp_fault),
        .mem_req      (mem_req),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_byte_en  (mem_byte_en),
        .mem_data_in  (mem_data_in),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    // Drives one request and acts as the memory with a fixed number of wait states.
    // Cycle 1 is the cycle after the accepting edge.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] bus_data,
                           input int waits, output obs_t o);
        int bus_seen;
        o = '0;
        bus_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        mem_data_in = bus_data; mem_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
        o.stable = 1'b1;
        o.timed_out = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (mem_req) begin
                if (bus_seen == 0) begin
                    o.addr = mem_addr; o.be = mem_byte_en; o.dout = mem_data_out; o.we_seen = mem_write_en;
                end else if (mem_addr !== o.addr || mem_byte_en !== o.be ||
                             mem_data_out !== o.dout || mem_write_en !== o.we_seen) begin
                    o.stable = 1'b0;
                end
                mem_ready = (bus_seen == waits);
                bus_seen++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            if (rsp_valid) begin
                o.rsp_cyc = 32'(c); o.rdata = rsp_rdata; o.misalign = rsp_misalign; o.fault = rsp_fault;
                o.timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        o.bus_cyc = 32'(bus_seen);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        o.pulse_ok = !rsp_valid && req_ready && (rsp_rdata == 0) && !rsp_fault && !rsp_misalign;
    endtask

    // Reference behaviour derived from the access rules with plain arithmetic.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] bus_data,
                         input int waits, output obs_t e);
        int nb, off;
        logic legal;
        longint m, v;
        e = '0;
        e.stable = 1'b1;
        e.pulse_ok = 1'b1;
        nb = 1 << (int'(f3) % 4);
        off = int'(addr % 4);
        legal = we ? (f3 < 3) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        m = (64'd1 << (8 * nb)) - 1;
        if (!legal) begin
            e.fault = 1'b1; e.rsp_cyc = 1;
        end else if (addr % nb != 0) begin
            e.misalign = 1'b1; e.rsp_cyc = 1;
        end else begin
            e.addr = addr - 32'(off);
            e.be = 4'(((1 << nb) - 1) << off);
            e.we_seen = we;
            e.dout = 0;
            for (int k = 0; k < 4 / nb; k++) e.dout = e.dout | 32'((longint'(wdata) & m) << (8 * nb * k));
            if (waits >= TIMEOUT) begin
                e.fault = 1'b1; e.bus_cyc = TIMEOUT; e.rsp_cyc = TIMEOUT + 1;
            end else begin
                e.bus_cyc = 32'(waits + 1); e.rsp_cyc = 32'(waits + 2);
                if (!we) begin
                    v = (longint'(bus_data) >> (8 * off)) & m;
                    if (f3 < 4 && v > (m >> 1)) v = v - (m + 1);
                    e.rdata = 32'(v);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({req_ready, mem_req, rsp_valid, rsp_misalign, rsp_fault, mem_write_en} !== 6'b100000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=100000",
                {req_ready, mem_req, rsp_valid, rsp_misalign, rsp_fault, mem_write_en});
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({rsp_rdata, mem_addr, mem_data_out, mem_byte_en, req_ready} !== {100'd0, 1'b1}) begin
            bad++; $display("FAIL reset_data rdata=%h addr=%h dout=%h be=%h ready=%b want zeros/ready=1",
                rsp_rdata, mem_addr, mem_data_out, mem_byte_en, req_ready);
        end
        $display("reset checked");
    endtask

    task automatic test_directed();
        obs_t o;
        run_txn(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF_1234, 0, o);
        $display("txn LB 0x203 rdata=%h cyc=%0d", o.rdata, o.rsp_cyc);
        total++; if (o.be !== 4'h8) begin bad++; $display("FAIL lb_be got=%h want=8", o.be); end
        total++; if (o.rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h want=ffffff80", o.rdata); end
        total++; if (o.rsp_cyc !== 2) begin bad++; $display("FAIL lb_latency got=%0d want=2", o.rsp_cyc); end

        run_txn(1'b1, 3'd1, 32'h102, 32'h0000_ABCD, 32'h0, 3, o);
        $display("txn SH 0x102 dout=%h be=%h cyc=%0d", o.dout, o.be, o.rsp_cyc);
        total++; if (o.dout !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_dout got=%h want=abcdabcd", o.dout); end
        total++; if (o.be !== 4'hC) begin bad++; $display("FAIL sh_be got=%h want=c", o.be); end
        total++; if (o.bus_cyc !== 4 || !o.stable || !o.we_seen) begin
            bad++; $display("FAIL sh_hold cycles=%0d stable=%b we=%b want 4/1/1", o.bus_cyc, o.stable, o.we_seen); end
        total++; if (o.rsp_cyc !== 5) begin bad++; $display("FAIL sh_latency got=%0d want=5", o.rsp_cyc); end

        run_txn(1'b0, 3'd2, 32'h101, 32'h0, 32'h1234_5678, 0, o);
        $display("txn LW 0x101 misalign=%b cyc=%0d", o.misalign, o.rsp_cyc);
        total++; if ({o.bus_cyc, o.misalign, o.fault, o.rsp_cyc} !== {32'd0, 2'b10, 32'd1}) begin
            bad++; $display("FAIL lw_misalign bus=%0d mis=%b fault=%b cyc=%0d want 0/1/0/1",
                o.bus_cyc, o.misalign, o.fault, o.rsp_cyc); end

        run_txn(1'b0, 3'd3, 32'h100, 32'h0, 32'h1234_5678, 0, o);
        $display("txn LD@32 fault=%b cyc=%0d", o.fault, o.rsp_cyc);
        total++; if ({o.bus_cyc, o.misalign, o.fault, o.rsp_cyc} !== {32'd0, 2'b01, 32'd1}) begin
            bad++; $display("FAIL ld_illegal bus=%0d mis=%b fault=%b cyc=%0d want 0/0/1/1",
                o.bus_cyc, o.misalign, o.fault, o.rsp_cyc); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 100, o);
        $display("txn LW timeout fault=%b bus=%0d cyc=%0d", o.fault, o.bus_cyc, o.rsp_cyc);
        total++; if ({o.bus_cyc, o.fault, o.rdata, o.rsp_cyc} !== {32'd4, 1'b1, 32'd0, 32'd5}) begin
            bad++; $display("FAIL timeout bus=%0d fault=%b rdata=%h cyc=%0d want 4/1/0/5",
                o.bus_cyc, o.fault, o.rdata, o.rsp_cyc); end
        @(negedge clk); mem_ready = 1'b1;
        @(posedge clk); #1; mem_ready = 1'b0;
        total++; if ({rsp_valid, mem_req, req_ready} !== 3'b001) begin
            bad++; $display("FAIL late_ready got=%b want=001", {rsp_valid, mem_req, req_ready}); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic saw_rsp;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100; mem_ready = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #2;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_bus mem_req got=%b want=1", mem_req); end
        reset = 1'b1; #1;
        total++; if ({mem_req, req_ready, rsp_valid} !== 3'b010) begin
            bad++; $display("FAIL reset_abort got=%b want=010", {mem_req, req_ready, rsp_valid}); end
        @(negedge clk); reset = 1'b0;
        saw_rsp = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (rsp_valid) saw_rsp = 1'b1; end
        total++; if (saw_rsp !== 1'b0) begin bad++; $display("FAIL reset_no_rsp got=%b want=0", saw_rsp); end
        run_txn(1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF_1234, 0, o);
        $display("txn LBU 0x203 rdata=%h cyc=%0d", o.rdata, o.rsp_cyc);
        total++; if ({o.rdata, o.rsp_cyc} !== {32'h80, 32'd2}) begin
            bad++; $display("FAIL lbu_after_reset rdata=%h cyc=%0d want 80/2", o.rdata, o.rsp_cyc); end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, bdata;
        int          waits;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom & 32'h0000_FFFF;
            wdata = $urandom;
            bdata = $urandom;
            waits = $urandom_range(0, 5);
            model(we, f3, addr, wdata, bdata, waits, e);
            run_txn(we, f3, addr, wdata, bdata, waits, o);
            $display("txn %0d we=%0d f3=%0d addr=%h waits=%0d rdata=%h fault=%b mis=%b",
                n, we, f3, addr, waits, o.rdata, o.fault, o.misalign);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL random_%0d got cyc=%0d rd=%h bus=%0d a=%h d=%h be=%h m=%b f=%b w=%b s=%b p=%b t=%b want cyc=%0d rd=%h bus=%0d a=%h d=%h be=%h m=%b f=%b w=%b",
                    n, o.rsp_cyc, o.rdata, o.bus_cyc, o.addr, o.dout, o.be, o.misalign, o.fault, o.we_seen,
                    o.stable, o.pulse_ok, o.timed_out, e.rsp_cyc, e.rdata, e.bus_cyc, e.addr, e.dout, e.be,
                    e.misalign, e.fault, e.we_seen);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        int acc_cyc [3];
        int accepted, got;
        logic ready_s;
        addrs[0] = 32'h400; addrs[1] = 32'h808; addrs[2] = 32'hC0C;
        accepted = 0; got = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = addrs[0];
        ready_s = req_ready;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(posedge clk);
            if (req_valid && ready_s) begin acc_cyc[accepted] = c; accepted++; end
            #1;
            if (accepted < 3) req_addr = addrs[accepted]; else req_valid = 1'b0;
            if (mem_req) begin mem_data_in = mem_addr ^ KEY; mem_ready = 1'b1; end
            else mem_ready = 1'b0;
            if (rsp_valid) begin
                $display("txn b2b %0d rdata=%h", got, rsp_rdata);
                total++;
                if (rsp_rdata !== (addrs[got] ^ KEY)) begin
                    bad++; $display("FAIL b2b_order_%0d got=%h want=%h", got, rsp_rdata, addrs[got] ^ KEY);
                end
                got++;
            end
            ready_s = req_ready;
        end
        req_valid = 1'b0; mem_ready = 1'b0;
        total++;
        if (got != 3 || accepted != 3) begin
            bad++; $display("FAIL b2b_count responses=%0d accepts=%0d want 3/3", got, accepted);
        end else begin
            total++;
            if (acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
                bad++; $display("FAIL b2b_spacing gaps=%0d,%0d want 3,3",
                    acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
